// File: rtl/shift_reg_pkg.sv
// Shared constants for the serial-in / parallel-out shift register.
//   SHREG_DEFAULT_WIDTH : default number of stages
//   SHIFT_DIR_LEFT      : D enters bit 0, data moves toward the MSB
//   SHIFT_DIR_RIGHT     : D enters the MSB, data moves toward bit 0
package shift_reg_pkg;

    localparam int SHREG_DEFAULT_WIDTH = 4;

    localparam bit SHIFT_DIR_LEFT  = 1'b1;
    localparam bit SHIFT_DIR_RIGHT = 1'b0;

endpackage : shift_reg_pkg

// File: rtl/shift_reg_stage.sv
// One stage of the shift register: a single D flop with synchronous clear.
// Ports:
//   clk : clock, state changes on rising edge
//   clr : synchronous active-high clear, loads RESET_BIT (beats d)
//   d   : next value when not clearing
//   q   : registered stage output
module shift_reg_stage #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic q_d;
    logic q_q;

    always_comb begin
        q_d = d;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q <= RESET_BIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : shift_reg_stage

// File: rtl/shift_reg_4bit.sv
// Serial-in, parallel-out shift register built from WIDTH chained stages.
// Parameters:
//   WIDTH       : number of stages / width of Q (2..32)
//   RESET_VALUE : value loaded into Q by CLR
//   SHIFT_LEFT  : 1 -> D enters Q[0], data moves toward MSB
//                 0 -> D enters Q[WIDTH-1], data moves toward LSB
// Ports:
//   CLK : clock, all state changes on rising edge
//   CLR : synchronous active-high clear (has priority over shifting)
//   D   : serial data in
//   Q   : parallel register contents, straight from the stage flops
module shift_reg_4bit
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH       = SHREG_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               SHIFT_LEFT  = SHIFT_DIR_LEFT
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] shreg_q;   // current stage outputs
    logic [WIDTH-1:0] shreg_d;   // per-stage next value from the chain

    // Chain each stage to its neighbour; D feeds the entry end.
    always_comb begin
        shreg_d = shreg_q;
        if (SHIFT_LEFT == SHIFT_DIR_LEFT) begin
            shreg_d = {shreg_q[WIDTH-2:0], D};
        end else begin
            shreg_d = {D, shreg_q[WIDTH-1:1]};
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        shift_reg_stage #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_stage (
            .clk (CLK),
            .clr (CLR),
            .d   (shreg_d[i]),
            .q   (shreg_q[i])
        );
    end

    assign Q = shreg_q;

endmodule : shift_reg_4bit

// File: tb/tb_shift_reg_4bit.sv
// Scoreboard bench: the driver pushes hand-computed expectations for the
// coming edge; the monitor pops and compares after every rising edge.
// Three instances share CLK/CLR/D: 4-bit left, 4-bit right, 8-bit left.
module tb_shift_reg_4bit;

    logic       CLK;
    logic       CLR;
    logic       D;
    logic [3:0] q_l4;
    logic [3:0] q_r4;
    logic [7:0] q_l8;

    shift_reg_4bit #(.WIDTH(4)) dut_l4 (.CLK(CLK), .CLR(CLR), .D(D), .Q(q_l4));
    shift_reg_4bit #(.WIDTH(4), .SHIFT_LEFT(1'b0)) dut_r4 (.CLK(CLK), .CLR(CLR), .D(D), .Q(q_r4));
    shift_reg_4bit #(.WIDTH(8)) dut_l8 (.CLK(CLK), .CLR(CLR), .D(D), .Q(q_l8));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int          id;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] get_q(input int id);
        case (id)
            0:       return {28'd0, q_l4};
            1:       return {28'd0, q_r4};
            default: return {24'd0, q_l8};
        endcase
    endfunction

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endfunction

    task automatic drive(input logic d, input logic clr);
        @(negedge CLK);
        D   = d;
        CLR = clr;
    endtask

    task automatic expect_q(input int id, input logic [31:0] v, input string nm);
        exp_t e;
        e.id = id; e.val = v; e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: everything queued before an edge refers to that edge.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            while (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check(e.name, get_q(e.id), e.val);
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    logic [3:0] fill4 [4];
    logic [7:0] fill8 [8];
    logic       pat_d [5];
    logic [3:0] pat_l [5];
    logic [3:0] pat_r [5];

    initial begin
        fill4 = '{4'h1, 4'h3, 4'h7, 4'hF};
        fill8 = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        pat_d = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        pat_l = '{4'h1, 4'h2, 4'h5, 4'hB, 4'h6};
        pat_r = '{4'h8, 4'h4, 4'hA, 4'hD, 4'h6};

        CLR = 1'b0;
        D   = 1'b0;

        // Reset from X
        drive(1'b0, 1'b1);
        expect_q(0, 32'h0, "reset_l4");
        expect_q(1, 32'h0, "reset_r4");
        expect_q(2, 32'h0, "reset_l8");
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0);
            expect_q(0, 32'h0, "hold0_l4");
            expect_q(2, 32'h0, "hold0_l8");
        end

        // Fill with ones: left 4-bit, right 4-bit (first two edges), 8-bit
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0);
            expect_q(0, (i < 4) ? {28'd0, fill4[i]} : 32'hF, "fill_l4");
            if (i == 0) expect_q(1, 32'h8, "fill_r4");
            if (i == 1) expect_q(1, 32'hC, "fill_r4");
            expect_q(2, {24'd0, fill8[i]}, "fill_l8");
        end

        // Ninth edge with D=0
        drive(1'b0, 1'b0);
        expect_q(2, 32'hFE, "w8_edge9");
        expect_q(0, 32'hE, "w4_shift0");

        // Mid-stream clear
        drive(1'b0, 1'b1);
        expect_q(0, 32'h0, "clr_mid_l4");
        expect_q(1, 32'h0, "clr_mid_r4");
        expect_q(2, 32'h0, "clr_mid_l8");

        // Pattern with overflow of the MSB on edge 5
        for (int i = 0; i < 5; i++) begin
            drive(pat_d[i], 1'b0);
            expect_q(0, {28'd0, pat_l[i]}, "pattern_l4");
            expect_q(1, {28'd0, pat_r[i]}, "pattern_r4");
        end

        // Back to 1111 on the left instance
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0);
        expect_q(0, 32'hF, "refill_l4");

        // CLR pulse entirely within CLK low: no effect
        @(negedge CLK);
        #1 CLR = 1'b1;
        #1 CLR = 1'b0;
        #1 check("clr_no_edge_l4", {28'd0, q_l4}, 32'hF);

        // Clear beats D=1
        D   = 1'b1;
        CLR = 1'b1;
        expect_q(0, 32'h0, "clr_beats_d_l4");
        expect_q(1, 32'h0, "clr_beats_d_r4");
        expect_q(2, 32'h0, "clr_beats_d_l8");

        // Shifting resumes from the reset value
        drive(1'b1, 1'b0);
        expect_q(0, 32'h1, "resume_l4");
        expect_q(1, 32'h8, "resume_r4");
        expect_q(2, 32'h01, "resume_l8");

        // Drain the scoreboard
        repeat (2) @(posedge CLK);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_shift_reg_4bit

// File: doc/shift_reg_4bit.md
Name: shift_reg_4bit

Overview:
Serial-in, parallel-out shift register; default width 4 bits, parameterisable. One serial data bit enters per rising clock edge, and all stages are visible on a parallel output bus. Used as a small deserialiser or delay-tap element in lab-level datapaths; it has no handshake.

Parameters:
WIDTH, 4, number of stages / width of Q (legal range 2..32).
RESET_VALUE, {WIDTH{1'b0}}, value loaded into Q by CLR.
SHIFT_LEFT, 1, 1: D enters Q[0] and data moves toward the MSB; 0: D enters Q[WIDTH-1] and data moves toward the LSB.

Ports:
CLK  input  1  system clock; all state changes on its rising edge.
CLR  input  1  synchronous active-high clear.
D    input  1  serial data in.
Q    output WIDTH  parallel register contents, registered output.

Behaviour:
- One clock domain (CLK). Reset is synchronous and active-high on CLR. No asynchronous paths.
- On each rising CLK edge:
  - If CLR=1, Q <= RESET_VALUE (all zeros by default). CLR has priority over shifting, and D is ignored on that edge.
  - Else if SHIFT_LEFT=1, Q <= {Q[WIDTH-2:0], D}.
  - Else, Q <= {D, Q[WIDTH-1:1]}.
- A CLR pulse that rises and falls with no rising CLK edge inside it has no effect; Q holds.
- Between rising edges, Q holds. Changes on D or CLR between edges are invisible until the next edge.
- Latency: a bit sampled on D appears at Q[0] (left mode) one edge later. It reaches Q[WIDTH-1] after WIDTH edges and is discarded on edge WIDTH+1.
- Power-up value of Q is undefined (X in simulation). Users must assert CLR across at least one rising edge before relying on Q.
- CLR asserted mid-stream clears all stages on that edge. Shifting resumes on the next edge with CLR=0, starting from RESET_VALUE.
- Q is driven directly from flops; there is no combinational path from D or CLR to Q.

Decomposition:
- Shared package shift_reg_pkg:
  - default width constant SHREG_DEFAULT_WIDTH = 4
  - direction constants SHIFT_DIR_LEFT = 1 and SHIFT_DIR_RIGHT = 0
- One natural sub-module: shift_reg_stage, a single D flop with synchronous clear and a 1-bit reset value.
  - The top instantiates WIDTH stages in a generate loop.
  - Each stage's D input is chained according to SHIFT_LEFT.

Test Plan:
- Reset: hold CLR=1 across one rising edge with Q=X -> Q=4'b0000 after the edge; Q stays 0 with CLR=0, D=0 over 2 further edges.
- Fill ones: after reset, D=1 for 4 edges -> Q = 0001, 0011, 0111, 1111 after edges 1..4 (SHIFT_LEFT=1).
- Pattern/overflow: from 0000, shift D = 1,0,1,1,0 -> Q = 0001, 0010, 0101, 1011, 0110; the MSB 1 is discarded on edge 5.
- Clear without clock: from Q=1111, pulse CLR high then low entirely while CLK=0 -> Q remains 1111; then one edge with CLR=1, D=1 -> Q=0000 (clear beats D).
- Right-shift variant (SHIFT_LEFT=0): from 0000, D=1 for 2 edges -> Q = 1000, then 1100.
- Width variant (WIDTH=8): from reset, D=1 for 8 edges -> Q=8'hFF; a ninth edge with D=0 -> Q=8'hFE.
